plic_claim_ctrl: RTL and testbench

- Bus initiator for one PLIC hart context; the hardware counterpart of a software interrupt handler.
- When the target's external-interrupt line is raised, it reads the claim/complete register over reg_intf and hands the claimed ID to a local consumer.
- After the consumer signals service done, it writes the same ID back to the complete register.
- Sits between the PLIC's per-target irq output and an accelerator or DMA engine that services interrupts without a core.

---
 rtl/plic_claim_ctrl.sv | 140 ++++++++++++++
 tb/tb_plic_claim_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_ctrl.sv
// PLIC claim/complete bus initiator for one hart context: claims an interrupt
// ID on irq, hands it to a local consumer, then writes it back as completion.

package reg_intf;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_intf_resp_d32;

endpackage

module plic_claim_ctrl #(
  parameter int unsigned NumSource = 31,
  parameter int unsigned TargetId  = 0,
  parameter logic [31:0] BaseAddr  = 32'h0C00_0000,
  localparam int unsigned IdW      = $clog2(NumSource + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         irq_i,
  output reg_intf::reg_intf_req_a32_d32 req_o,
  input  reg_intf::reg_intf_resp_d32   resp_i,
  output logic                         id_valid_o,
  output logic [IdW-1:0]               id_o,
  input  logic                         id_ready_i,
  input  logic                         done_i,
  output logic                         busy_o,
  output logic                         err_o,
  input  logic                         err_clr_i,
  output logic [7:0]                   spurious_cnt_o
);

  // The claim and complete registers share one address per context.
  localparam logic [31:0] ClaimAddr =
    BaseAddr + 32'h0020_0004 + 32'(TargetId) * 32'h0000_1000;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_RD,
    DELIVER,
    SERVICE,
    COMPLETE_WR,
    ERROR
  } state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] id_q, id_d;
  logic [7:0]     spur_q, spur_d;
  logic           claim_spurious;

  // ID 0 means "nothing pending"; anything above NumSource cannot be a real source.
  assign claim_spurious = (resp_i.rdata == 32'd0) || (resp_i.rdata > 32'(NumSource));

  // NOTE: asynchronous reset plus non-blocking assignments only, so every
  // register updates from the same pre-edge values and reset needs no clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      spur_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      spur_q  <= spur_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    spur_d  = spur_q;
    req_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (irq_i) state_d = CLAIM_RD;
      end

      CLAIM_RD: begin
        req_o.valid = 1'b1;
        req_o.addr  = ClaimAddr;
        if (resp_i.ready) begin
          if (resp_i.error) begin
            state_d = ERROR;
          end else if (claim_spurious) begin
            state_d = IDLE;
            if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
          end else begin
            id_d    = resp_i.rdata[IdW-1:0];
            state_d = DELIVER;
          end
        end
      end

      DELIVER: begin
        if (id_ready_i) state_d = SERVICE;
      end

      // done_i is only meaningful once the consumer has taken the ID.
      SERVICE: begin
        if (done_i) state_d = COMPLETE_WR;
      end

      COMPLETE_WR: begin
        req_o.valid = 1'b1;
        req_o.write = 1'b1;
        req_o.addr  = ClaimAddr;
        req_o.wdata = {{(32-IdW){1'b0}}, id_q};
        req_o.wstrb = 4'hF;
        if (resp_i.ready) state_d = resp_i.error ? ERROR : IDLE;
      end

      ERROR: begin
        if (err_clr_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // All outputs decode registered state, so reset removes them asynchronously.
  assign id_valid_o     = (state_q == DELIVER);
  assign id_o           = id_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = (state_q == ERROR);
  assign spurious_cnt_o = spur_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Scoreboard bench for plic_claim_ctrl: a bus responder plus a monitor that
// compares every bus transaction and ID handoff against a reference queue.

module tb_plic_claim_ctrl;
  import reg_intf::*;

  localparam logic [31:0] NUM_SOURCE = 32'd31;
  localparam int          ID_W       = 5;
  localparam logic [31:0] ADDR_T1    = 32'h0C20_1004;
  localparam logic [31:0] ADDR_T0    = 32'h0C20_0004;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq = 1'b0, id_ready = 1'b0, done = 1'b0, err_clr = 1'b0;
  reg_intf_req_a32_d32 req;
  reg_intf_resp_d32    resp;
  logic                id_valid, busy, err;
  logic [ID_W-1:0]     id;
  logic [7:0]          spur_cnt;

  // Second instance only proves the TargetId=0 address.
  logic                irq0 = 1'b0;
  reg_intf_req_a32_d32 req0;
  reg_intf_resp_d32    resp0;
  logic                id_valid0, busy0, err0;
  logic [ID_W-1:0]     id0;
  logic [7:0]          spur_cnt0;
  assign resp0 = '0;

  always #5 clk = ~clk;

  plic_claim_ctrl #(.NumSource(31), .TargetId(1), .BaseAddr(32'h0C00_0000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .req_o(req), .resp_i(resp),
    .id_valid_o(id_valid), .id_o(id), .id_ready_i(id_ready), .done_i(done),
    .busy_o(busy), .err_o(err), .err_clr_i(err_clr), .spurious_cnt_o(spur_cnt)
  );

  plic_claim_ctrl #(.NumSource(31), .TargetId(0), .BaseAddr(32'h0C00_0000)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq0), .req_o(req0), .resp_i(resp0),
    .id_valid_o(id_valid0), .id_o(id0), .id_ready_i(1'b0), .done_i(1'b0),
    .busy_o(busy0), .err_o(err0), .err_clr_i(1'b0), .spurious_cnt_o(spur_cnt0)
  );

  // Responder: ready after a programmable number of stall cycles per access.
  logic [31:0] rsp_rdata = '0;
  int          rsp_wait_rd = 0, rsp_wait_wr = 0;
  logic        rsp_err_rd = 1'b0, rsp_err_wr = 1'b0;
  int          wait_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       wait_cnt <= 0;
    else if (req.valid && !resp.ready) wait_cnt <= wait_cnt + 1;
    else                              wait_cnt <= 0;
  end

  always_comb begin
    resp       = '0;
    resp.ready = req.valid && (wait_cnt >= (req.write ? rsp_wait_wr : rsp_wait_rd));
    resp.rdata = rsp_rdata;
    resp.error = req.write ? rsp_err_wr : rsp_err_rd;
  end

  // Scoreboard state and reference model.
  txn_t            exp_bus[$];
  logic [ID_W-1:0] exp_id[$];
  int              spur_model = 0;
  int              n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk_txn(input logic w, input logic [31:0] d, input logic [3:0] s);
    return '{write: w, addr: ADDR_T1, wdata: d, wstrb: s};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  txn_t            cur_txn, prev_txn;
  logic            prev_stall, prev_fire, prev_idv;
  logic [ID_W-1:0] prev_id;
  assign cur_txn = {req.write, req.addr, req.wdata, req.wstrb};

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_fire  <= 1'b0;
      prev_idv   <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 96'(req.valid), 96'(1));
        check("hold_fields", 96'(cur_txn), 96'(prev_txn));
      end
      if (prev_fire) check("gap_after_txn", 96'(req.valid), 96'(0));
      if (req.valid && resp.ready) begin
        check("bus_txn_expected", 96'(exp_bus.size() != 0), 96'(1));
        if (exp_bus.size() != 0) check("bus_txn", 96'(cur_txn), 96'(exp_bus.pop_front()));
      end
      if (id_valid && !prev_idv) check("id_expected", 96'(exp_id.size() != 0), 96'(1));
      if (id_valid && prev_idv)  check("id_stable", 96'(id), 96'(prev_id));
      if (id_valid && id_ready && exp_id.size() != 0)
        check("id_value", 96'(id), 96'(exp_id.pop_front()));
      prev_stall <= req.valid && !resp.ready;
      prev_fire  <= req.valid && resp.ready;
      prev_idv   <= id_valid;
      prev_id    <= id;
      prev_txn   <= cur_txn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = id_valid, 1 = idle, 2 = error flag
  task automatic wait_until(input int which, input string name);
    int k = 0;
    while (!((which == 0 && id_valid) || (which == 1 && !busy) || (which == 2 && err))
           && k < 200) begin
      tick();
      k++;
    end
    check(name, 96'(k < 200), 96'(1));
  endtask

  task automatic recover_from_error();
    wait_until(2, "wait_error");
    check("err_set", 96'(err), 96'(1));
    irq = 1'b1;
    repeat (4) begin
      tick();
      check("error_bus_quiet", 96'(req.valid), 96'(0));
    end
    rsp_rdata   = 32'd0;
    rsp_wait_rd = 0;
    rsp_err_rd  = 1'b0;
    exp_bus.push_back(mk_txn(1'b0, 32'h0, 4'h0));
    spur_model = sat_inc(spur_model);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 96'(err), 96'(0));
    tick();
    irq = 1'b0;
    check("claim_after_clear", 96'({req.valid, req.write}), 96'(2'b10));
  endtask

  task automatic run_claim(input logic [31:0] rdata, input int w_rd, input int w_wr,
                           input logic e_rd, input logic e_wr, input int rdy_dly,
                           input int done_dly, input logic early_done,
                           input logic done_with_ready);
    logic            spur;
    logic [ID_W-1:0] cid;
    spur = (rdata == 32'd0) || (rdata > NUM_SOURCE);
    cid  = rdata[ID_W-1:0];
    rsp_rdata   = rdata;
    rsp_wait_rd = w_rd;
    rsp_wait_wr = w_wr;
    rsp_err_rd  = e_rd;
    rsp_err_wr  = e_wr;
    exp_bus.push_back(mk_txn(1'b0, 32'h0, 4'h0));
    if (!e_rd && spur) spur_model = sat_inc(spur_model);
    if (!e_rd && !spur) begin
      exp_id.push_back(cid);
      exp_bus.push_back(mk_txn(1'b1, 32'(cid), 4'hF));
    end
    irq = 1'b1;
    tick();
    irq = 1'b0;
    if (!e_rd && !spur) begin
      wait_until(0, "wait_id_valid");
      repeat (rdy_dly) begin
        done = early_done;
        tick();
        done = 1'b0;
      end
      id_ready = 1'b1;
      done     = done_with_ready;
      tick();
      id_ready = 1'b0;
      done     = 1'b0;
      repeat (done_dly) tick();
      check("service_bus_quiet", 96'(req.valid), 96'(0));
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    if (e_rd || (!spur && e_wr)) recover_from_error();
    wait_until(1, "wait_idle");
    check("spurious_cnt", 96'(spur_cnt), 96'(spur_model));
    check("err_low", 96'(err), 96'(0));
  endtask

  function automatic logic [31:0] rand_spurious();
    int sel = int'($urandom_range(0, 2));
    if (sel == 0) return 32'd0;
    if (sel == 1) return 32'($urandom_range(32, 255));
    return $urandom() | 32'h8000_0000;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_req", 96'(req), 96'(0));
    check("rst_id_valid", 96'(id_valid), 96'(0));
    check("rst_id", 96'(id), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_err", 96'(err), 96'(0));
    check("rst_spur", 96'(spur_cnt), 96'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    irq0 = 1'b1;
    tick();
    irq0 = 1'b0;
    check("t0_claim_valid", 96'({req0.valid, req0.write, req0.wstrb}), 96'(6'b10_0000));
    check("t0_claim_addr", 96'(req0.addr), 96'(ADDR_T0));

    // Zero-wait claim of ID 5 with cycle-exact latency checks.
    rsp_rdata = 32'd5;
    exp_bus.push_back(mk_txn(1'b0, 32'h0, 4'h0));
    exp_id.push_back(5'd5);
    exp_bus.push_back(mk_txn(1'b1, 32'd5, 4'hF));
    irq = 1'b1;
    tick();
    irq = 1'b0;
    check("lat_claim_valid", 96'({req.valid, req.write}), 96'(2'b10));
    tick();
    check("lat_id_valid", 96'(id_valid), 96'(1));
    check("lat_id", 96'(id), 96'(5));
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("lat_complete_wr", 96'({req.valid, req.write}), 96'(2'b11));
    tick();
    check("lat_idle", 96'(busy), 96'(0));

    run_claim(32'd7, 4, 4, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);    // stalled responder
    run_claim(32'd0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);    // spurious: zero
    run_claim(32'd40, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // spurious: out of range
    run_claim(32'd9, 0, 0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);    // completion error
    run_claim(32'd12, 1, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);   // claim read error
    run_claim(32'd12, 0, 0, 1'b0, 1'b0, 3, 2, 1'b1, 1'b1);   // early done ignored

    for (int i = 0; i < 260; i++)
      run_claim(rand_spurious(), int'($urandom_range(0, 2)), 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] v;
      if ($urandom_range(0, 2) != 0) v = 32'($urandom_range(1, 31));
      else                           v = rand_spurious();
      run_claim(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a stalled claim read.
    rsp_rdata   = 32'd3;
    rsp_wait_rd = 1000;
    irq = 1'b1;
    tick();
    irq = 1'b0;
    repeat (2) tick();
    check("stall_before_reset", 96'(req.valid), 96'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 96'(req), 96'(0));
    check("arst_busy", 96'(busy), 96'(0));
    check("arst_id_valid", 96'(id_valid), 96'(0));
    check("arst_id", 96'(id), 96'(0));
    check("arst_err", 96'(err), 96'(0));
    check("arst_spur", 96'(spur_cnt), 96'(0));
    spur_model = 0;
    rsp_wait_rd = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", 96'({req.valid, busy}), 96'(0));
    check("post_reset_spur", 96'(spur_cnt), 96'(spur_model));
    check("bus_queue_drained", 96'(exp_bus.size()), 96'(0));
    check("id_queue_drained", 96'(exp_id.size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
